// File: rtl/ram_dp_param.sv
// Dual-port (one write, one read) register-file RAM with registered read data,
// per-entry written tracking, write-first bypass and a sticky range-error flag.
module ram_dp_param #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  unwritten,
  output logic                  err
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DEPTH-1:0]      r_written;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_unwritten;
  logic                  r_err;

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_addr_err;
  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_unwritten;

  // Request qualification.
  always_comb begin
    w_wr_in_range = ({1'b0, addr_in}  < LP_DEPTH);
    w_rd_in_range = ({1'b0, addr_out} < LP_DEPTH);
    w_wr_acc      = enable & wr_en & w_wr_in_range;
    w_rd_acc      = enable & rd_en & w_rd_in_range;
    w_addr_err    = enable & ((wr_en & ~w_wr_in_range) | (rd_en & ~w_rd_in_range));
    w_bypass      = w_wr_acc & (addr_in == addr_out);
  end

  // Read data select: same-edge write wins, never-written entries read as zero.
  always_comb begin
    w_rd_data      = '0;
    w_rd_unwritten = 1'b0;
    if (w_bypass) begin
      w_rd_data = data_in;
    end else if (r_written[addr_out]) begin
      w_rd_data = r_mem[addr_out];
    end else begin
      w_rd_unwritten = 1'b1;
    end
  end

  // Storage is not reset; the written bits hide stale contents.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[addr_in] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_written   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_unwritten <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_written[addr_in] <= 1'b1;
      end
      r_valid_out <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out  <= w_rd_data;
        r_unwritten <= w_rd_unwritten;
      end
      if (w_addr_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign unwritten = r_unwritten;
  assign err       = r_err;

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: DEPTH=8 and DEPTH=6 instances driven in lockstep,
// checked against an array-based behavioural model.
module tb_ram_dp_param;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          enable;
  logic          wr_en;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [AW-1:0] addr_out;

  logic [DW-1:0] dout8, dout6;
  logic          v8, v6, u8, u6, e8, e6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_dp_param #(.DATA_WIDTH(DW), .DEPTH(8), .ADDR_WIDTH(AW)) dut8 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .wr_en(wr_en),
    .addr_in(addr_in), .data_in(data_in), .rd_en(rd_en), .addr_out(addr_out),
    .data_out(dout8), .valid_out(v8), .unwritten(u8), .err(e8));

  ram_dp_param #(.DATA_WIDTH(DW), .DEPTH(6), .ADDR_WIDTH(AW)) dut6 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .wr_en(wr_en),
    .addr_in(addr_in), .data_in(data_in), .rd_en(rd_en), .addr_out(addr_out),
    .data_out(dout6), .valid_out(v6), .unwritten(u6), .err(e6));

  // Reference model: index 0 models DEPTH=8, index 1 models DEPTH=6.
  int unsigned   depth_of [2] = '{8, 6};
  logic [DW-1:0] m_mem  [2][8];
  bit            m_wr   [2][8];
  logic [DW-1:0] m_dout [2];
  bit            m_v    [2];
  bit            m_u    [2];
  bit            m_e    [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_wr[k][i] = 1'b0;
      m_dout[k] = '0;
      m_v[k]    = 1'b0;
      m_u[k]    = 1'b0;
      m_e[k]    = 1'b0;
    end
  endtask

  // Effect of one rising edge given the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int unsigned d = depth_of[k];
      bit wacc = enable && wr_en && (int'(addr_in)  < int'(d));
      bit racc = enable && rd_en && (int'(addr_out) < int'(d));
      if (enable && ((wr_en && int'(addr_in) >= int'(d)) || (rd_en && int'(addr_out) >= int'(d))))
        m_e[k] = 1'b1;
      m_v[k] = racc;
      if (racc) begin
        if (wacc && addr_in == addr_out) begin
          m_dout[k] = data_in;
          m_u[k]    = 1'b0;
        end else if (m_wr[k][addr_out]) begin
          m_dout[k] = m_mem[k][addr_out];
          m_u[k]    = 1'b0;
        end else begin
          m_dout[k] = '0;
          m_u[k]    = 1'b1;
        end
      end
      if (wacc) begin
        m_mem[k][addr_in] = data_in;
        m_wr[k][addr_in]  = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dout8"},  8'(dout8), 8'(m_dout[0]));
    check({tag, "_valid8"}, 8'(v8),    8'(m_v[0]));
    check({tag, "_unw8"},   8'(u8),    8'(m_u[0]));
    check({tag, "_err8"},   8'(e8),    8'(m_e[0]));
    check({tag, "_dout6"},  8'(dout6), 8'(m_dout[1]));
    check({tag, "_valid6"}, 8'(v6),    8'(m_v[1]));
    check({tag, "_unw6"},   8'(u6),    8'(m_u[1]));
    check({tag, "_err6"},   8'(e6),    8'(m_e[1]));
  endtask

  // Drive inputs (called just after an edge), advance one edge, then check.
  task automatic cycle(input bit en, input bit we, input int ai, input int di,
                       input bit re, input int ao, input string tag);
    enable   = en;
    wr_en    = we;
    addr_in  = AW'(ai);
    data_in  = DW'(di);
    rd_en    = re;
    addr_out = AW'(ao);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L  = 1'b0;
    enable   = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    addr_in  = '0;
    addr_out = '0;
    data_in  = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
    #1;
    model_reset();
    check_all("por");
    #1;
    reset_L = 1'b1;

    // Write 0xA to 3, read it back.
    cycle(1, 1, 3, 'hA, 0, 0, "wr3");
    cycle(1, 0, 0, 0,   1, 3, "rd3");
    check("rd3_direct", 8'(dout8), 8'hA);

    // Never-written entry reads as zero with unwritten.
    cycle(1, 0, 0, 0, 1, 5, "rd5");
    check("rd5_unw_direct", 8'(u8), 8'h1);

    // Write-first bypass at addr 2 (previously 0x1).
    cycle(1, 1, 2, 'h1, 0, 0, "wr2");
    cycle(1, 1, 2, 'h7, 1, 2, "byp2");
    check("byp2_direct", 8'(dout8), 8'h7);

    // Independent write and read at different addresses.
    cycle(1, 1, 4, 'hC, 1, 3, "wr4rd3");

    // Disabled requests are ignored.
    cycle(1, 1, 6, 'hF, 0, 0, "wr6");
    cycle(0, 1, 6, 'h0, 1, 6, "dis");
    check("dis_valid_direct", 8'(v8), 8'h0);
    cycle(1, 0, 0, 0, 1, 6, "rd6");
    check("rd6_direct", 8'(dout8), 8'hF);

    // Out-of-range on DEPTH=6 sets sticky err; normal traffic keeps it.
    cycle(1, 1, 7, 'h5, 0, 0, "wr7");
    check("wr7_err6_direct", 8'(e6), 8'h1);
    cycle(1, 0, 0, 0, 1, 7, "rd7");
    cycle(1, 1, 1, 'h9, 1, 1, "norm1");
    cycle(0, 0, 0, 0, 0, 0, "idle");
    do_reset("rst_err");

    // Fill every entry, reset between edges, then every entry is unwritten.
    for (int i = 0; i < 8; i++) cycle(1, 1, i, 15 - i, 0, 0, "fill");
    do_reset("rst_fill");
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 1, i, "after_rst");

    // In-flight read discarded by reset; next edge is a normal accepting edge.
    cycle(1, 1, 0, 'h3, 0, 0, "wr0");
    cycle(1, 0, 0, 0, 1, 0, "rd0");
    do_reset("rst_inflight");
    cycle(1, 1, 1, 'h6, 1, 1, "post_rst");

    // Randomized back-to-back traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 60) == 0) do_reset("rnd_rst");
      cycle(($urandom_range(0, 4) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
RAM_DP_PARAM -- requirements
Module: ram_dp_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: bits per entry.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries (2..2**ADDR_WIDTH; need not be a power of two).
REQ-003 SHALL have parameter ADDR_WIDTH, default 3: width of both address ports.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_L  input  1: asynchronous reset, active-low.
REQ-006 SHALL have port enable  input  1: global enable; when 0, no read or write is accepted.
REQ-007 SHALL have port wr_en  input  1: write request this cycle.
REQ-008 SHALL have port addr_in  input  ADDR_WIDTH: write address.
REQ-009 SHALL have port data_in  input  DATA_WIDTH: write data.
REQ-010 SHALL have port rd_en  input  1: read request this cycle.
REQ-011 SHALL have port addr_out  input  ADDR_WIDTH: read address.
REQ-012 SHALL have port data_out  output  DATA_WIDTH: registered read data.
REQ-013 SHALL have port valid_out  output  1: data_out holds the result of a read accepted on the previous edge.
REQ-014 SHALL have port unwritten  output  1: the entry read had not been written since reset.
REQ-015 SHALL have port err  output  1: sticky out-of-range address flag.

Function
REQ-016 SHALL accept a write at a rising edge when enable=1, wr_en=1 and addr_in<DEPTH: mem[addr_in]<=data_in, written[addr_in]<=1.
REQ-017 SHALL accept a read at a rising edge when enable=1, rd_en=1 and addr_out<DEPTH; the result SHALL appear on data_out with valid_out=1 one cycle later (latency 1).
REQ-018 SHALL, on any edge with no accepted read, drive valid_out=0 and hold data_out and unwritten at their previous values.
REQ-019 SHALL, for an accepted read of an entry with written=0, drive data_out=0 and unwritten=1; otherwise unwritten=0.
REQ-020 SHALL, for a simultaneous accepted write and read at the same address, return the new data_in on data_out (write-first bypass) with unwritten=0.
REQ-021 SHALL, for simultaneous write and read at different addresses, perform both independently in the same cycle.
REQ-022 SHALL ignore a request whose address is >=DEPTH (no memory or written-bit change, no valid_out) and set err=1.
REQ-023 SHALL keep err=1 until reset; err is unaffected by enable.
REQ-024 SHALL ignore wr_en and rd_en entirely when enable=0: no memory change, valid_out=0, err unchanged.
REQ-025 SHALL allow a write and a read every cycle back-to-back with no bubbles.

Reset
REQ-026 SHALL, while reset_L=0 and independent of clk, drive data_out=0, valid_out=0, unwritten=0, err=0 and clear all written bits.
REQ-027 SHALL NOT require memory array contents to be cleared; the cleared written bits make stale contents unobservable.
REQ-028 SHALL, on reset assertion mid-operation, discard any in-flight read result; the first edge after deassertion SHALL be a normal, accepting edge.

Verification
REQ-029 Reset then write 0xA to addr 3, then read addr 3 -> one cycle later data_out=0xA, valid_out=1, unwritten=0.
REQ-030 After reset, read addr 5 (never written) -> data_out=0, valid_out=1, unwritten=1.
REQ-031 Same edge: write 0x7 to addr 2 while reading addr 2 (previously 0x1) -> next cycle data_out=0x7, valid_out=1.
REQ-032 Write 0xF to addr 6, then enable=0 with wr_en=1 (addr 6, 0x0) and rd_en=1 -> valid_out=0; re-enable and read addr 6 -> data_out=0xF.
REQ-033 DEPTH=6, ADDR_WIDTH=3: write addr 7 -> err=1, no valid_out; err stays 1 across normal traffic until reset_L=0.
REQ-034 Write all 8 entries (DATA_WIDTH=4), pulse reset_L low between clock edges, then read each -> data_out=0, unwritten=1 for every entry.
